// File: rtl/turf_infra_pkg.sv
// TURF infrastructure shared types: supervisor state encoding and
// DCM STATUS bit positions.
package turf_infra_pkg;

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } turf_state_e;

  localparam int STAT_PHASE_OVF  = 0;
  localparam int STAT_CLKIN_STOP = 1;

  function automatic int tmr_width(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/turf_clk_supervisor_if.sv
// DCM status/control and per-SURF enable bundle of the TURF
// clock supervisor.
interface turf_clk_supervisor_if #(
  parameter int NUM_SURFS = 12,
  parameter int CNT_W     = 16
);

  logic                 dcm_locked_i;
  logic [1:0]           dcm_status_i;
  logic                 dcm_reset_i;
  logic [NUM_SURFS-1:0] surf_mask_i;
  logic [NUM_SURFS-1:0] ref_mask_i;
  logic                 dcm_reset_o;
  logic                 clk_ok_o;
  logic                 fault_o;
  logic [2:0]           state_o;
  logic [CNT_W-1:0]     relock_count_o;
  logic [NUM_SURFS-1:0] surf_en_o;
  logic [NUM_SURFS-1:0] ref_pulse_o;

  modport master (
    output dcm_locked_i,
    output dcm_status_i,
    output dcm_reset_i,
    output surf_mask_i,
    output ref_mask_i,
    input  dcm_reset_o,
    input  clk_ok_o,
    input  fault_o,
    input  state_o,
    input  relock_count_o,
    input  surf_en_o,
    input  ref_pulse_o
  );

  modport slave (
    input  dcm_locked_i,
    input  dcm_status_i,
    input  dcm_reset_i,
    input  surf_mask_i,
    input  ref_mask_i,
    output dcm_reset_o,
    output clk_ok_o,
    output fault_o,
    output state_o,
    output relock_count_o,
    output surf_en_o,
    output ref_pulse_o
  );

endinterface

// File: rtl/turf_sync2.sv
// Two-flop synchroniser for slow asynchronous status levels,
// clears to zero on reset.
module turf_sync2 #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= d_i;
      r_sync <= r_meta;
    end
  end

  assign q_o = r_sync;

endmodule

// File: rtl/turf_clk_supervisor.sv
// TURF clock supervisor: sequences the 125->250 MHz DCM, qualifies
// lock, counts relocks, gates SURF enables and emits ref pulses.
module turf_clk_supervisor
  import turf_infra_pkg::*;
#(
  parameter int NUM_SURFS     = 12,
  parameter int RST_CYCLES    = 8,
  parameter int LOCK_TIMEOUT  = 65535,
  parameter int SETTLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 4,
  parameter int REF_PERIOD    = 33000,
  parameter int CNT_W         = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  turf_clk_supervisor_if.slave bus
);

  localparam int TW = tmr_width(RST_CYCLES, LOCK_TIMEOUT,
                                SETTLE_CYCLES);
  localparam int RW = $clog2(MAX_RETRIES + 1);
  localparam int PW = $clog2(REF_PERIOD);

  logic [2:0]           w_sync;
  logic                 w_lock;
  logic [1:0]           w_status;
  logic                 w_stop;
  logic                 w_unused_ovf;
  turf_state_e          w_nxt;
  logic                 w_retry_inc;
  logic                 w_retry_clr;
  logic                 w_relock;
  logic                 w_restart;
  logic                 w_tick;
  logic                 w_run_hold;

  turf_state_e          r_state;
  logic [TW-1:0]        r_timer;
  logic [RW-1:0]        r_retry;
  logic [CNT_W-1:0]     r_relock;
  logic                 r_dcm_rst;
  logic                 r_clk_ok;
  logic                 r_fault;
  logic [PW-1:0]        r_ref_cnt;
  logic [NUM_SURFS-1:0] r_surf_en;
  logic [NUM_SURFS-1:0] r_pulse;

  turf_sync2 #(.W(3)) u_sync (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .d_i     ({bus.dcm_status_i, bus.dcm_locked_i}),
    .q_o     (w_sync)
  );

  assign w_lock       = w_sync[0];
  assign w_status     = w_sync[2:1];
  assign w_stop       = w_status[STAT_CLKIN_STOP];
  // Phase overflow is informational only; it never drops lock.
  assign w_unused_ovf = w_status[STAT_PHASE_OVF];

  always_comb begin
    w_nxt       = r_state;
    w_retry_inc = 1'b0;
    w_retry_clr = 1'b0;
    w_relock    = 1'b0;
    if (bus.dcm_reset_i) begin
      w_nxt       = ST_RESET;
      w_retry_clr = 1'b1;
    end else begin
      unique case (r_state)
        ST_RESET: begin
          if (r_timer == TW'(RST_CYCLES - 1))
            w_nxt = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (w_lock)
            w_nxt = ST_SETTLE;
          else if (r_timer == TW'(LOCK_TIMEOUT - 1))
            w_retry_inc = 1'b1;
        end
        ST_SETTLE: begin
          if (!w_lock || w_stop) begin
            w_retry_inc = 1'b1;
          end else if (r_timer == TW'(SETTLE_CYCLES - 1)) begin
            w_nxt       = ST_RUN;
            w_retry_clr = 1'b1;
          end
        end
        ST_RUN: begin
          if (!w_lock || w_stop) begin
            w_nxt       = ST_RESET;
            w_relock    = 1'b1;
            w_retry_clr = 1'b1;
          end
        end
        ST_FAULT: ;
        default: w_nxt = ST_RESET;
      endcase
      if (w_retry_inc)
        w_nxt = (r_retry == RW'(MAX_RETRIES - 1)) ?
                ST_FAULT : ST_RESET;
    end
  end

  assign w_restart  = bus.dcm_reset_i || (w_nxt != r_state);
  assign w_tick     = (r_state == ST_RESET) ||
                      (r_state == ST_WAIT_LOCK) ||
                      (r_state == ST_SETTLE);
  assign w_run_hold = (r_state == ST_RUN) && (w_nxt == ST_RUN);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state   <= ST_RESET;
      r_timer   <= '0;
      r_retry   <= '0;
      r_relock  <= '0;
      r_dcm_rst <= 1'b1;
      r_clk_ok  <= 1'b0;
      r_fault   <= 1'b0;
      r_ref_cnt <= '0;
      r_surf_en <= '0;
      r_pulse   <= '0;
    end else begin
      r_state   <= w_nxt;
      r_dcm_rst <= (w_nxt == ST_RESET) || (w_nxt == ST_FAULT);
      r_clk_ok  <= (w_nxt == ST_RUN);
      r_fault   <= (w_nxt == ST_FAULT);
      if (w_restart)
        r_timer <= '0;
      else if (w_tick)
        r_timer <= r_timer + 1'b1;
      if (w_retry_clr)
        r_retry <= '0;
      else if (w_retry_inc)
        r_retry <= r_retry + 1'b1;
      if (w_relock && (r_relock != {CNT_W{1'b1}}))
        r_relock <= r_relock + 1'b1;
      if ((w_nxt == ST_RUN) && (r_state != ST_RUN))
        r_ref_cnt <= '0;
      else if (r_state == ST_RUN)
        r_ref_cnt <= (r_ref_cnt == PW'(REF_PERIOD - 1)) ?
                     '0 : r_ref_cnt + 1'b1;
      // Gate on staying in RUN so a pulse never escapes on exit.
      r_surf_en <= w_run_hold ? bus.surf_mask_i : '0;
      r_pulse   <= (w_run_hold &&
                    (r_ref_cnt == PW'(REF_PERIOD - 1))) ?
                   (bus.ref_mask_i & bus.surf_mask_i) : '0;
    end
  end

  assign bus.dcm_reset_o    = r_dcm_rst;
  assign bus.clk_ok_o       = r_clk_ok;
  assign bus.fault_o        = r_fault;
  assign bus.state_o        = r_state;
  assign bus.relock_count_o = r_relock;
  assign bus.surf_en_o      = r_surf_en;
  assign bus.ref_pulse_o    = r_pulse;

endmodule
